// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: RBR read sequencing, sticky line status, character timeout and RX interrupt.
// Optional character-timeout logic is built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned TIMEOUT_CHARS = 4,
  parameter int unsigned CNT_W         = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en_i,
  input  logic       fifo_en_i,
  input  logic       tick_i,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       stop_bit_num_i,
  input  logic       rx_data_valid_i,
  input  logic       parity_err_i,
  input  logic       stop_bit_err_i,
  input  logic       fifo_overrun_i,
  input  logic       fifo_empty_i,
  input  logic       fifo_triggered_i,
  input  logic       rd_req_i,
  input  logic       rd_lsr_i,
  input  logic [2:0] ier_i,
  output logic       fifo_pop_o,
  output logic       rd_ack_o,
  output logic [3:0] lsr_o,
  output logic [3:0] iir_o,
  output logic       int_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_LINE = 4'b0110;
  localparam logic [3:0] IIR_DATA = 4'b0100;
  localparam logic [3:0] IIR_TMO  = 4'b1100;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] lsr_nxt;
  logic [3:0] iir_nxt;
  logic       timeout_pend;
  logic       timeout_ie;

  // Read sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: pop only when a FIFO entry exists, otherwise ack straight away
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_req_i) begin
          state_nxt = (fifo_en_i && !fifo_empty_i) ? ST_POP : ST_ACK;
        end
      end
      ST_POP:  state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_ACK;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line status next value; set pulses win over the clear
  always_comb begin
    lsr_nxt = lsr_o;
    if (fifo_en_i) begin
      lsr_nxt[0] = !fifo_empty_i;
    end else if (rx_data_valid_i) begin
      lsr_nxt[0] = 1'b1;
    end else if (state == ST_ACK) begin
      lsr_nxt[0] = 1'b0;
    end
    lsr_nxt[1] = fifo_overrun_i || (!fifo_en_i && rx_data_valid_i && lsr_o[0]) ||
                 (lsr_o[1] && !rd_lsr_i);
    lsr_nxt[2] = parity_err_i || (lsr_o[2] && !rd_lsr_i);
    lsr_nxt[3] = stop_bit_err_i || (lsr_o[3] && !rd_lsr_i);
  end

  // Prioritised interrupt identification
  always_comb begin
    iir_nxt = IIR_NONE;
    if ((|lsr_o[3:1]) && ier_i[1]) begin
      iir_nxt = IIR_LINE;
    end else if ((fifo_en_i ? fifo_triggered_i : lsr_o[0]) && ier_i[0]) begin
      iir_nxt = IIR_DATA;
    end else if (timeout_pend && timeout_ie) begin
      iir_nxt = IIR_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_pop_o <= 1'b0;
      rd_ack_o   <= 1'b0;
      lsr_o      <= 4'b0000;
      iir_o      <= IIR_NONE;
      int_o      <= 1'b0;
    end else begin
      fifo_pop_o <= (state_nxt == ST_POP);
      rd_ack_o   <= (state_nxt == ST_ACK);
      lsr_o      <= lsr_nxt;
      iir_o      <= iir_nxt;
      int_o      <= !iir_nxt[0];
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [3:0]       char_bits;
  logic [CNT_W-1:0] timeout_thr;
  logic [CNT_W-1:0] timeout_cnt;
  logic             cnt_clr;
  logic             pend_clr;

  // Frame length in bits: start + data + parity + stop
  assign char_bits   = 4'd7 + 4'(data_bit_num_i) + 4'(parity_en_i) + 4'(stop_bit_num_i);
  assign timeout_thr = CNT_W'(TIMEOUT_CHARS * 32'd16 * 32'(char_bits));
  assign cnt_clr     = rx_data_valid_i || rd_req_i || fifo_empty_i || !fifo_en_i || !rx_en_i;
  assign pend_clr    = rd_req_i || rx_data_valid_i || fifo_empty_i;
  assign timeout_ie  = ier_i[2];

  // Saturating idle-tick counter and timeout pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_cnt  <= '0;
      timeout_pend <= 1'b0;
    end else begin
      if (cnt_clr) begin
        timeout_cnt <= '0;
      end else if (tick_i && (timeout_cnt != {CNT_W{1'b1}})) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
      if (pend_clr) begin
        timeout_pend <= 1'b0;
      end else if (timeout_cnt >= timeout_thr) begin
        timeout_pend <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_pend   = 1'b0;
  assign timeout_ie     = 1'b0;
  assign unused_timeout = ^{rx_en_i, tick_i, data_bit_num_i, parity_en_i, stop_bit_num_i,
                            ier_i[2], TIMEOUT_CHARS[0], CNT_W[0]};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_uart_rx_ctrl;

  localparam int unsigned TC = 4;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en_i = 1'b0;
  logic       fifo_en_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [1:0] data_bit_num_i = 2'd3;
  logic       parity_en_i = 1'b0;
  logic       stop_bit_num_i = 1'b0;
  logic       rx_data_valid_i = 1'b0;
  logic       parity_err_i = 1'b0;
  logic       stop_bit_err_i = 1'b0;
  logic       fifo_overrun_i = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic       fifo_triggered_i = 1'b0;
  logic       rd_req_i = 1'b0;
  logic       rd_lsr_i = 1'b0;
  logic [2:0] ier_i = 3'b000;
  logic       fifo_pop_o;
  logic       rd_ack_o;
  logic [3:0] lsr_o;
  logic [3:0] iir_o;
  logic       int_o;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.TIMEOUT_CHARS(TC), .CNT_W(12)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_en_i          (rx_en_i),
    .fifo_en_i        (fifo_en_i),
    .tick_i           (tick_i),
    .data_bit_num_i   (data_bit_num_i),
    .parity_en_i      (parity_en_i),
    .stop_bit_num_i   (stop_bit_num_i),
    .rx_data_valid_i  (rx_data_valid_i),
    .parity_err_i     (parity_err_i),
    .stop_bit_err_i   (stop_bit_err_i),
    .fifo_overrun_i   (fifo_overrun_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_triggered_i (fifo_triggered_i),
    .rd_req_i         (rd_req_i),
    .rd_lsr_i         (rd_lsr_i),
    .ier_i            (ier_i),
    .fifo_pop_o       (fifo_pop_o),
    .rd_ack_o         (rd_ack_o),
    .lsr_o            (lsr_o),
    .iir_o            (iir_o),
    .int_o            (int_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles left in the current read, whether it pops, status and idle ticks
  int         m_rem = 0;
  bit         m_pop_txn = 1'b0;
  logic [3:0] m_lsr = 4'b0000;
  logic [3:0] m_iir = 4'b0001;
  int         m_idle = 0;
  bit         m_pend = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  // Advance the model across one rising edge using the inputs present before it
  task automatic model_edge();
    logic [3:0] old;
    int         thr;
    bit         ack_now;
    old = m_lsr;
    if (reset) begin
      m_rem = 0; m_pop_txn = 1'b0; m_lsr = 4'b0000; m_iir = 4'b0001; m_idle = 0; m_pend = 1'b0;
      return;
    end
    if ((|old[3:1]) && ier_i[1])                                m_iir = 4'b0110;
    else if ((fifo_en_i ? fifo_triggered_i : old[0]) && ier_i[0]) m_iir = 4'b0100;
    else if (TO_EN && m_pend && ier_i[2])                       m_iir = 4'b1100;
    else                                                        m_iir = 4'b0001;
    ack_now = (m_rem == 1);
    if (m_rem > 0) m_rem--;
    else if (rd_req_i) begin
      m_pop_txn = fifo_en_i && !fifo_empty_i;
      m_rem = m_pop_txn ? 3 : 1;
    end
    if (fifo_en_i)            m_lsr[0] = !fifo_empty_i;
    else if (rx_data_valid_i) m_lsr[0] = 1'b1;
    else if (ack_now)         m_lsr[0] = 1'b0;
    m_lsr[1] = fifo_overrun_i || (!fifo_en_i && rx_data_valid_i && old[0]) || (old[1] && !rd_lsr_i);
    m_lsr[2] = parity_err_i || (old[2] && !rd_lsr_i);
    m_lsr[3] = stop_bit_err_i || (old[3] && !rd_lsr_i);
    thr = TC * 16 * (7 + int'(data_bit_num_i) + int'(parity_en_i) + int'(stop_bit_num_i));
    if (rd_req_i || rx_data_valid_i || fifo_empty_i) m_pend = 1'b0;
    else if (m_idle >= thr)                          m_pend = 1'b1;
    if (rd_req_i || rx_data_valid_i || fifo_empty_i || !fifo_en_i || !rx_en_i) m_idle = 0;
    else if (tick_i && m_idle < 4095)                                        m_idle++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("fifo_pop", 4'(fifo_pop_o), 4'(m_pop_txn && m_rem == 3));
    chk("rd_ack", 4'(rd_ack_o), 4'(m_rem == 1));
    chk("lsr", lsr_o, m_lsr);
    chk("iir", iir_o, m_iir);
    chk("int", 4'(int_o), 4'(!m_iir[0]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    bit quiet;
    // Reset values
    reset = 1'b1;
    repeat (2) cyc();
    chk("reset_lsr", lsr_o, 4'b0000);
    chk("reset_iir", iir_o, 4'b0001);
    chk("reset_int", 4'(int_o), 4'd0);
    chk("reset_ack", 4'(rd_ack_o), 4'd0);

    // FIFO read: pop at +1, ack at +3, second request mid-read ignored
    reset = 1'b0; rx_en_i = 1'b1; fifo_en_i = 1'b1; fifo_empty_i = 1'b0;
    repeat (2) cyc();
    rd_req_i = 1'b1; cyc();
    rd_req_i = 1'b0;
    chk("t1_pop_c1", 4'(fifo_pop_o), 4'd1);
    chk("t1_ack_c1", 4'(rd_ack_o), 4'd0);
    cyc();
    chk("t1_pop_c2", 4'(fifo_pop_o), 4'd0);
    rd_req_i = 1'b1; cyc();
    rd_req_i = 1'b0;
    chk("t1_ack_c3", 4'(rd_ack_o), 4'd1);
    chk("t1_pop_c3", 4'(fifo_pop_o), 4'd0);
    repeat (3) begin
      cyc();
      chk("t1_no_extra_pop", 4'(fifo_pop_o), 4'd0);
      chk("t1_no_extra_ack", 4'(rd_ack_o), 4'd0);
    end

    // Holding mode: overrun, LSR read clears errors, RBR read clears data_ready
    do_reset();
    fifo_en_i = 1'b0; fifo_empty_i = 1'b1;
    rx_data_valid_i = 1'b1; cyc();
    rx_data_valid_i = 1'b0; cyc();
    rx_data_valid_i = 1'b1; cyc();
    rx_data_valid_i = 1'b0;
    chk("t2_overrun", lsr_o, 4'b0011);
    rd_lsr_i = 1'b1; cyc();
    rd_lsr_i = 1'b0;
    chk("t2_lsr_read", lsr_o, 4'b0001);
    rd_req_i = 1'b1; cyc();
    rd_req_i = 1'b0;
    chk("t2_ack_1clk", 4'(rd_ack_o), 4'd1);
    cyc();
    chk("t2_lsr_clear", lsr_o, 4'b0000);

    // Character timeout, 8N1, one byte waiting
    do_reset();
    fifo_en_i = 1'b1; fifo_empty_i = 1'b0; fifo_triggered_i = 1'b0; ier_i = 3'b101;
    data_bit_num_i = 2'd3; parity_en_i = 1'b0; stop_bit_num_i = 1'b0;
    for (int i = 0; i < 639; i++) begin
      tick_i = 1'b1; cyc();
      tick_i = 1'b0; cyc();
    end
    chk("t3_no_early_tmo", iir_o, 4'b0001);
    tick_i = 1'b1; cyc();
    tick_i = 1'b0;
    repeat (3) cyc();
    chk("t3_tmo_iir", iir_o, TO_EN ? 4'b1100 : 4'b0001);
    chk("t3_tmo_int", 4'(int_o), TO_EN ? 4'd1 : 4'd0);
    rd_req_i = 1'b1; cyc();
    rd_req_i = 1'b0;
    repeat (2) cyc();
    chk("t3_int_clear", 4'(int_o), 4'd0);
    repeat (3) cyc();

    // Line status outranks data available
    do_reset();
    fifo_triggered_i = 1'b1; ier_i = 3'b111;
    parity_err_i = 1'b1; cyc();
    parity_err_i = 1'b0; cyc();
    chk("t4_line_iir", iir_o, 4'b0110);
    rd_lsr_i = 1'b1; cyc();
    rd_lsr_i = 1'b0; cyc();
    chk("t4_data_iir", iir_o, 4'b0100);

    // All sources active, all disabled
    ier_i = 3'b000; parity_err_i = 1'b1; stop_bit_err_i = 1'b1; fifo_overrun_i = 1'b1;
    repeat (3) cyc();
    parity_err_i = 1'b0; stop_bit_err_i = 1'b0; fifo_overrun_i = 1'b0;
    chk("t5_lsr_errs", lsr_o, 4'b1111);
    chk("t5_iir_none", iir_o, 4'b0001);
    chk("t5_int_none", 4'(int_o), 4'd0);

    // Reset while waiting for FIFO data
    do_reset();
    fifo_triggered_i = 1'b0;
    rd_req_i = 1'b1; cyc();
    rd_req_i = 1'b0; cyc();
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("t6_ack", 4'(rd_ack_o), 4'd0);
    chk("t6_lsr", lsr_o, 4'b0000);
    chk("t6_iir", iir_o, 4'b0001);
    repeat (4) begin
      cyc();
      chk("t6_no_late_ack", 4'(rd_ack_o), 4'd0);
    end

    // Randomized traffic with long quiet windows to exercise the timeout
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      quiet = (i % 1500) >= 600;
      if (i % 250 == 0) begin
        fifo_en_i      = 1'($urandom_range(0, 1));
        ier_i          = 3'($urandom);
        data_bit_num_i = 2'($urandom);
        parity_en_i    = 1'($urandom_range(0, 1));
        stop_bit_num_i = 1'($urandom_range(0, 1));
        rx_en_i        = ($urandom_range(0, 3) != 0);
      end
      if (quiet) begin
        fifo_en_i = 1'b1; rx_en_i = 1'b1; fifo_empty_i = 1'b0; tick_i = 1'b1;
        rx_data_valid_i = 1'b0; parity_err_i = 1'b0; stop_bit_err_i = 1'b0; fifo_overrun_i = 1'b0;
        rd_req_i = ($urandom_range(0, 1199) == 0);
        rd_lsr_i = ($urandom_range(0, 99) == 0);
        reset = 1'b0;
      end else begin
        tick_i          = ($urandom_range(0, 1) == 1);
        rx_data_valid_i = ($urandom_range(0, 19) == 0);
        parity_err_i    = ($urandom_range(0, 39) == 0);
        stop_bit_err_i  = ($urandom_range(0, 39) == 0);
        fifo_overrun_i  = ($urandom_range(0, 59) == 0);
        rd_req_i        = ($urandom_range(0, 7) == 0);
        rd_lsr_i        = ($urandom_range(0, 14) == 0);
        reset           = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 29) == 0) fifo_empty_i = !fifo_empty_i;
      end
      if ($urandom_range(0, 9) == 0) fifo_triggered_i = !fifo_triggered_i;
      cyc();
    end
    reset = 1'b0; rd_req_i = 1'b0; rd_lsr_i = 1'b0; rx_data_valid_i = 1'b0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
